intr_edge_latch: RTL and testbench

Upstream conditioning stage for the interrupt capturer. It converts raw asynchronous interrupt sources into clean, active-high, sticky level interrupts.
- Each source is synchronised, then either edge-latched or passed through as a level, as configured per bit.
- Results are masked and driven to the capturer's interrupt inputs.
- An Avalon-MM-style slave provides status, masking, clearing and software-forced interrupts, with the same one-cycle registered read latency as the capturer.

---
 rtl/intr_edge_latch_if.sv | 23 ++
 rtl/intr_edge_latch.sv | 148 ++++++++++++++
 tb/tb_intr_edge_latch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/intr_edge_latch_if.sv
// intr_edge_latch_if
//   Register-access bus for intr_edge_latch. The protocol follows Avalon-MM:
//   read/write are single-cycle strobes. rddata is registered and is valid
//   the cycle after read.
//   Signals:
//     addr    3-bit word address
//     read    read strobe
//     write   write strobe
//     wrdata  32-bit write data
//     rddata  32-bit registered read data
`timescale 1ns/1ps
interface intr_edge_latch_if;
   logic [2:0]  addr;
   logic        read;
   logic        write;
   logic [31:0] wrdata;
   logic [31:0] rddata;

   modport master (output addr, output read, output write, output wrdata,
                   input rddata);
   modport slave  (input addr, input read, input write, input wrdata,
                   output rddata);
endinterface

// File: rtl/intr_edge_latch.sv
// intr_edge_latch
//   Conditions raw asynchronous interrupt sources into sticky active-high
//   levels for the interrupt capturer. Each source passes through a
//   synchroniser. Each bit is then either rising-edge latched or passed
//   through as a level, selected by EDGE_SEL. The result is masked and
//   registered.
//
//   Ports:
//     clk            single clock
//     rst            asynchronous active-high reset
//     irq_src        raw interrupt sources (asynchronous, active high)
//     bus            register slave (addr/read/write/wrdata/rddata)
//     irq_level_out  registered PENDING & MASK
//     irq_any        registered OR of the same product
//
//   Register map (word address):
//     0 PENDING  read / write-1-to-clear (W1C has no effect on level-mode bits)
//     1 MASK     read/write, resets to all ones
//     2 RAW      synchronised source levels, read only
//     3 FORCE    write-1 sets PENDING on the following edge, reads 0
//     4 OVERRUN  read / write-1-to-clear, only when built with the option
//     5-7        read 0
//
//   Build option: INTR_EDGE_LATCH_OVERRUN_EN adds the OVERRUN register.
//   Without it, address 4 reads 0 and ignores writes.
`timescale 1ns/1ps
module intr_edge_latch #(
   parameter int          NUM_INTR    = 32,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] EDGE_SEL    = 32'hFFFF_FFFF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_INTR-1:0] irq_src,
   intr_edge_latch_if.slave    bus,
   output logic [NUM_INTR-1:0] irq_level_out,
   output logic                irq_any
);

   localparam logic [NUM_INTR-1:0] EDGE_MASK = EDGE_SEL[NUM_INTR-1:0];

   logic [SYNC_STAGES-1:0][NUM_INTR-1:0] sync_q;
   logic [NUM_INTR-1:0] sync;
   logic [NUM_INTR-1:0] sync_d;
   logic [NUM_INTR-1:0] edge_cond;
   logic [NUM_INTR-1:0] clr_q;
   logic [NUM_INTR-1:0] force_q;
   logic [NUM_INTR-1:0] pending;
   logic [NUM_INTR-1:0] pending_nxt;
   logic [NUM_INTR-1:0] mask;
   logic [NUM_INTR-1:0] wr_bits;
   logic [NUM_INTR-1:0] masked;
   logic [31:0]         rd_word;
   logic                wr_pend;
   logic                wr_mask;
   logic                wr_force;

   assign sync      = sync_q[SYNC_STAGES-1];
   assign edge_cond = sync & ~sync_d;
   assign wr_bits   = bus.wrdata[NUM_INTR-1:0];
   assign wr_pend   = bus.write && (bus.addr == 3'd0);
   assign wr_mask   = bus.write && (bus.addr == 3'd1);
   assign wr_force  = bus.write && (bus.addr == 3'd3);
   assign masked    = pending & mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         sync_d <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
         sync_d <= sync;
      end
   end

   // Registering the W1C and FORCE strobes means both act on the edge after
   // the bus write. A read that coincides with the write therefore still
   // returns the value from before the write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_q   <= '0;
         force_q <= '0;
      end else begin
         clr_q   <= wr_pend  ? wr_bits : '0;
         force_q <= wr_force ? wr_bits : '0;
      end
   end

   // Edge bits are sticky, and a set takes priority over a clear on the same
   // edge. Level bits track sync. A FORCE on a level bit holds it high for
   // exactly one cycle.
   always_comb begin
      pending_nxt = (EDGE_MASK & ((pending & ~clr_q) | edge_cond | force_q))
                  | (~EDGE_MASK & (sync | force_q));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         mask    <= '1;
      end else begin
         pending <= pending_nxt;
         if (wr_mask) mask <= wr_bits;
      end
   end

`ifdef INTR_EDGE_LATCH_OVERRUN_EN
   logic [NUM_INTR-1:0] overrun;
   logic [NUM_INTR-1:0] ovr_hit;
   logic [NUM_INTR-1:0] ovr_clr;

   // An overrun is a new event on a bit that is already pending and is not
   // being cleared on this edge.
   assign ovr_hit = EDGE_MASK & (edge_cond | force_q) & pending & ~clr_q;
   assign ovr_clr = (bus.write && (bus.addr == 3'd4)) ? wr_bits : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) overrun <= '0;
      else     overrun <= (overrun & ~ovr_clr) | ovr_hit;
   end
`endif

   always_comb begin
      rd_word = '0;
      case (bus.addr)
         3'd0: rd_word[NUM_INTR-1:0] = pending;
         3'd1: rd_word[NUM_INTR-1:0] = mask;
         3'd2: rd_word[NUM_INTR-1:0] = sync;
`ifdef INTR_EDGE_LATCH_OVERRUN_EN
         3'd4: rd_word[NUM_INTR-1:0] = overrun;
`endif
         default: rd_word = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rddata    <= '0;
         irq_level_out <= '0;
         irq_any       <= 1'b0;
      end else begin
         if (bus.read) bus.rddata <= rd_word;
         irq_level_out <= masked;
         irq_any       <= |masked;
      end
   end

endmodule

// File: tb/tb_intr_edge_latch.sv
`timescale 1ns/1ps
module tb_intr_edge_latch;
   localparam int          NI  = 32;
   localparam int          SS  = 2;
   localparam logic [31:0] ESEL = 32'hFFFF_FFDF;

   logic          clk;
   logic          rst;
   logic [NI-1:0] irq_src;
   logic [NI-1:0] irq_level_out;
   logic          irq_any;

   intr_edge_latch_if bus_if ();

   intr_edge_latch #(.NUM_INTR(NI), .SYNC_STAGES(SS), .EDGE_SEL(ESEL)) dut (
      .clk           (clk),
      .rst           (rst),
      .irq_src       (irq_src),
      .bus           (bus_if.slave),
      .irq_level_out (irq_level_out),
      .irq_any       (irq_any)
   );

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard pop: called once the DUT has registered the read data.
   task automatic pop_check(input string tag);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s observed=%h expected=<none queued>", tag, bus_if.rddata);
      end else begin
         e = exp_q.pop_front();
         assert (bus_if.rddata === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, bus_if.rddata, e);
         end
      end
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
      bus_if.addr = a;
      bus_if.read = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      bus_if.read = 1'b0;
      pop_check(tag);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus_if.addr   = a;
      bus_if.wrdata = d;
      bus_if.write  = 1'b1;
      @(negedge clk);
      bus_if.write  = 1'b0;
   endtask

   task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp,
                     input string tag);
      bus_if.addr   = a;
      bus_if.wrdata = d;
      bus_if.write  = 1'b1;
      bus_if.read   = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      bus_if.write  = 1'b0;
      bus_if.read   = 1'b0;
      pop_check(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      irq_src = '0;
      bus_if.addr = '0;
      bus_if.read = 1'b0;
      bus_if.write = 1'b0;
      bus_if.wrdata = '0;
      tick(3);
      rst = 1'b0;
      tick(1);

      // 1: reset state
      chk("rst_lvl", irq_level_out, 32'h0);
      chk("rst_any", {31'b0, irq_any}, 32'h0);
      rd(3'd1, 32'hFFFF_FFFF, "rst_mask");
      rd(3'd0, 32'h0, "rst_pend");
      rd(3'd2, 32'h0, "rst_raw");
      rd(3'd4, 32'h0, "rst_ovr");
      rd(3'd6, 32'h0, "unused_addr");

      // 2: edge latency on bit 3 (first sampled at edge E)
      irq_src[3] = 1'b1;
      tick(2);                                  // after E+1
      chk("lat_lvl_e1", irq_level_out, 32'h0);
      rd(3'd0, 32'h0, "lat_pend_e2");           // sampled at E+2, before the update
      chk("lat_lvl_e2", irq_level_out, 32'h0);
      chk("lat_any_e2", {31'b0, irq_any}, 32'h0);
      rd(3'd0, 32'h8, "lat_pend_e3");           // PENDING set at E+2
      chk("lat_lvl_e3", irq_level_out, 32'h8);
      chk("lat_any_e3", {31'b0, irq_any}, 32'h1);
      rd(3'd2, 32'h8, "raw_bit3");
      irq_src[3] = 1'b0;
      tick(4);
      chk("sticky_lvl", irq_level_out, 32'h8);
      wr(3'd0, 32'h8);                          // write edge W
      chk("w1c_lvl_w", irq_level_out, 32'h8);
      tick(1);
      chk("w1c_lvl_w1", irq_level_out, 32'h8);
      tick(1);
      chk("w1c_lvl_w2", irq_level_out, 32'h0);
      chk("w1c_any_w2", {31'b0, irq_any}, 32'h0);
      rd(3'd0, 32'h0, "w1c_pend");

      // 3: masking
      wr(3'd1, 32'h0);
      irq_src[0] = 1'b1;
      tick(6);
      rd(3'd0, 32'h1, "mask_pend");
      chk("mask_lvl", irq_level_out, 32'h0);
      chk("mask_any", {31'b0, irq_any}, 32'h0);
      wr(3'd1, 32'h1);
      chk("unmask_lvl_w", irq_level_out, 32'h0);
      tick(1);
      chk("unmask_lvl_w1", irq_level_out, 32'h1);
      chk("unmask_any_w1", {31'b0, irq_any}, 32'h1);
      irq_src[0] = 1'b0;
      rw(3'd1, 32'hFFFF_FFFF, 32'h1, "rw_same_addr");
      rd(3'd1, 32'hFFFF_FFFF, "mask_after_rw");
      wr(3'd0, 32'h1);
      tick(3);
      rd(3'd0, 32'h0, "clr_bit0");

      // 4: level-mode bit 5
      irq_src[5] = 1'b1;
      tick(4);
      rd(3'd0, 32'h20, "lvl_pend");
      wr(3'd0, 32'h20);
      tick(2);
      rd(3'd0, 32'h20, "lvl_w1c_ignored");
      chk("lvl_out_hi", irq_level_out, 32'h20);
      irq_src[5] = 1'b0;                        // first low sample at L
      tick(3);                                  // after L+2
      chk("lvl_out_l2", irq_level_out, 32'h20);
      tick(1);                                  // after L+3
      chk("lvl_out_l3", irq_level_out, 32'h0);
      rd(3'd0, 32'h0, "lvl_pend_low");

      // 5: FORCE coincident with an edge on bit 7
      irq_src[7] = 1'b1;                        // first sampled at E
      tick(1);
      wr(3'd3, 32'h80);                         // write at E+1, both land at E+2
      tick(2);
      rd(3'd0, 32'h80, "force_edge_pend");
      rd(3'd3, 32'h0, "force_reads0");
      rd(3'd4, 32'h0, "ovr_none");
      irq_src[7] = 1'b0;
      tick(3);
      irq_src[7] = 1'b1;
      tick(4);
`ifdef INTR_EDGE_LATCH_OVERRUN_EN
      rd(3'd4, 32'h80, "ovr_set");
      rd(3'd0, 32'h80, "ovr_pend");
      wr(3'd4, 32'h80);
      rd(3'd4, 32'h0, "ovr_w1c");
`else
      wr(3'd4, 32'hFFFF_FFFF);
      rd(3'd4, 32'h0, "ovr_absent");
`endif
      // FORCE on level bit 5: one-cycle pulse
      wr(3'd3, 32'h20);                         // write edge W
      rd(3'd0, 32'h80, "lvl_force_w1");         // sampled W+1, before the update
      rd(3'd0, 32'hA0, "lvl_force_w2");
      rd(3'd0, 32'h80, "lvl_force_w3");

      // 6: reset mid-operation with a read in flight
      irq_src[7:0] = 8'hFF;
      tick(4);
      rd(3'd0, 32'hFF, "pre_rst_pend");
      bus_if.addr = 3'd1;
      bus_if.read = 1'b1;
      @(posedge clk);
      #1;
      chk("pre_rst_lvl", irq_level_out, 32'hFF);
      rst = 1'b1;
      #1;
      chk("rst_async_rd", bus_if.rddata, 32'h0);
      chk("rst_async_lvl", irq_level_out, 32'h0);
      chk("rst_async_any", {31'b0, irq_any}, 32'h0);
      bus_if.read = 1'b0;
      irq_src = '0;
      tick(2);
      rst = 1'b0;
      tick(3);
      rd(3'd0, 32'h0, "post_rst_pend");
      rd(3'd1, 32'hFFFF_FFFF, "post_rst_mask");
      rd(3'd4, 32'h0, "post_rst_ovr");
      chk("post_rst_lvl", irq_level_out, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
